// File: rtl/fft_pkg.sv
// Shared constants, FSM state encoding, write-back payload and address helpers
// for the radix-2 DIT FFT stage sequencer.
package fft_pkg;

    localparam int unsigned LOGN    = 4;
    localparam int unsigned RAM_LAT = 1;
    localparam int unsigned BF_LAT  = 4;
    localparam int unsigned N       = 1 << LOGN;
    localparam int unsigned HALF_N  = N / 2;
    localparam int unsigned D       = RAM_LAT + BF_LAT;
    localparam int unsigned KW      = LOGN - 1;
    localparam int unsigned CNT_W   = $clog2(D + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_DRAIN,
        ST_DONE
    } state_e;

    typedef struct packed {
        logic            valid;
        logic [LOGN-1:0] addr_a;
        logic [LOGN-1:0] addr_b;
    } wb_t;

    // Insert a zero at bit s of k: top of the butterfly pair within its group.
    function automatic logic [LOGN-1:0] calc_addr_a(input logic [KW-1:0] k,
                                                     input logic [LOGN-1:0] s);
        logic [LOGN-1:0] kk;
        logic [LOGN-1:0] mask;
        kk   = LOGN'(k);
        mask = (LOGN'(1) << s) - LOGN'(1);
        return ((kk >> s) << (s + LOGN'(1))) | (kk & mask);
    endfunction

    function automatic logic [KW-1:0] calc_tw(input logic [KW-1:0] k,
                                              input logic [LOGN-1:0] s);
        logic [LOGN-1:0] kk;
        logic [LOGN-1:0] mask;
        logic [LOGN-1:0] pos;
        kk   = LOGN'(k);
        mask = (LOGN'(1) << s) - LOGN'(1);
        pos  = kk & mask;
        return KW'(pos << (LOGN'(LOGN - 1) - s));
    endfunction

endpackage

// File: rtl/fft_wb_delay.sv
// Write-back delay line: carries {valid, addr_a, addr_b} from read issue to the
// cycle the butterfly results appear.
module fft_wb_delay
    import fft_pkg::*;
#(
    parameter int unsigned DEPTH = D
) (
    input  logic clk,
    input  logic rst,
    input  wb_t  din,
    output wb_t  dout
);

    wb_t [DEPTH-1:0] pipe_q;
    wb_t [DEPTH-1:0] pipe_d;

    always_comb begin
        pipe_d    = pipe_q;
        pipe_d[0] = din;
        for (int i = 1; i < int'(DEPTH); i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe_q <= '0;
        end else begin
            pipe_q <= pipe_d;
        end
    end

    assign dout = pipe_q[DEPTH-1];

endmodule

// File: rtl/fft_stage_seq.sv
// In-place radix-2 DIT FFT sequencer: issues per-stage butterfly read/twiddle
// addresses over ping-pong banks and aligns write-back with datapath latency.
module fft_stage_seq
    import fft_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    output logic            busy,
    output logic            done,
    output logic [LOGN-1:0] stage,
    output logic            rd_en,
    output logic            rd_bank,
    output logic [LOGN-1:0] rd_addr_a,
    output logic [LOGN-1:0] rd_addr_b,
    output logic [KW-1:0]   tw_addr,
    output logic            wr_en,
    output logic            wr_bank,
    output logic [LOGN-1:0] wr_addr_a,
    output logic [LOGN-1:0] wr_addr_b
);

    state_e            state_q, state_d;
    logic [KW-1:0]     k_q, k_d;
    logic [LOGN-1:0]   s_q, s_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [LOGN-1:0]   stage_q, stage_d;
    logic              rd_en_q, rd_en_d;
    logic              rd_bank_q, rd_bank_d;
    logic              wr_bank_q, wr_bank_d;
    logic [LOGN-1:0]   rd_addr_a_q, rd_addr_a_d;
    logic [LOGN-1:0]   rd_addr_b_q, rd_addr_b_d;
    logic [KW-1:0]     tw_addr_q, tw_addr_d;
    wb_t               wb_in;
    wb_t               wb_out;

    // Next state plus registered outputs, computed from the post-transition counters.
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        s_d     = s_q;
        cnt_d   = cnt_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        rd_en_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_ISSUE;
                    k_d     = '0;
                    s_d     = '0;
                    busy_d  = 1'b1;
                    rd_en_d = 1'b1;
                end
            end
            ST_ISSUE: begin
                busy_d = 1'b1;
                if (k_q == KW'(HALF_N - 1)) begin
                    state_d = ST_DRAIN;
                    cnt_d   = '0;
                end else begin
                    k_d     = k_q + KW'(1);
                    rd_en_d = 1'b1;
                end
            end
            ST_DRAIN: begin
                busy_d = 1'b1;
                if (cnt_q == CNT_W'(D - 1)) begin
                    if (s_q == LOGN'(LOGN - 1)) begin
                        state_d = ST_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_ISSUE;
                        s_d     = s_q + LOGN'(1);
                        k_d     = '0;
                        rd_en_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        stage_d     = busy_d ? s_d : '0;
        rd_bank_d   = busy_d & s_d[0];
        wr_bank_d   = busy_d & ~s_d[0];
        rd_addr_a_d = rd_addr_a_q;
        rd_addr_b_d = rd_addr_b_q;
        tw_addr_d   = tw_addr_q;
        if (rd_en_d) begin
            rd_addr_a_d = calc_addr_a(k_d, s_d);
            rd_addr_b_d = rd_addr_a_d + (LOGN'(1) << s_d);
            tw_addr_d   = calc_tw(k_d, s_d);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            k_q         <= '0;
            s_q         <= '0;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            stage_q     <= '0;
            rd_en_q     <= 1'b0;
            rd_bank_q   <= 1'b0;
            wr_bank_q   <= 1'b0;
            rd_addr_a_q <= '0;
            rd_addr_b_q <= '0;
            tw_addr_q   <= '0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            s_q         <= s_d;
            cnt_q       <= cnt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            stage_q     <= stage_d;
            rd_en_q     <= rd_en_d;
            rd_bank_q   <= rd_bank_d;
            wr_bank_q   <= wr_bank_d;
            rd_addr_a_q <= rd_addr_a_d;
            rd_addr_b_q <= rd_addr_b_d;
            tw_addr_q   <= tw_addr_d;
        end
    end

    always_comb begin
        wb_in        = '0;
        wb_in.valid  = rd_en_q;
        wb_in.addr_a = rd_addr_a_q;
        wb_in.addr_b = rd_addr_b_q;
    end

    fft_wb_delay #(
        .DEPTH (D)
    ) u_wb_delay (
        .clk  (clk),
        .rst  (rst),
        .din  (wb_in),
        .dout (wb_out)
    );

    assign busy      = busy_q;
    assign done      = done_q;
    assign stage     = stage_q;
    assign rd_en     = rd_en_q;
    assign rd_bank   = rd_bank_q;
    assign rd_addr_a = rd_addr_a_q;
    assign rd_addr_b = rd_addr_b_q;
    assign tw_addr   = tw_addr_q;
    assign wr_en     = wb_out.valid;
    assign wr_bank   = wr_bank_q;
    assign wr_addr_a = wb_out.addr_a;
    assign wr_addr_b = wb_out.addr_b;

endmodule

// File: tb/tb_fft_stage_seq.sv
// Directed self-checking bench for fft_stage_seq (N=16, D=5) with a sample-RAM
// and simplified butterfly model driven by the sequencer's strobes.
module tb_fft_stage_seq;
    import fft_pkg::*;

    localparam int NCAP    = 58;
    localparam int RUN_CYC = 53;
    localparam int STG_CYC = 13;

    logic            clk, rst, start;
    logic            busy, done, rd_en, rd_bank, wr_en, wr_bank;
    logic [LOGN-1:0] stage, rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b;
    logic [KW-1:0]   tw_addr;

    int n_checks = 0;
    int n_err    = 0;

    logic            h_rd_en [0:NCAP];
    logic            h_rd_bank [0:NCAP];
    logic            h_busy [0:NCAP];
    logic            h_done [0:NCAP];
    logic            h_wr_en [0:NCAP];
    logic            h_wr_bank [0:NCAP];
    logic [LOGN-1:0] h_stage [0:NCAP];
    logic [LOGN-1:0] h_ra [0:NCAP];
    logic [LOGN-1:0] h_rb [0:NCAP];
    logic [LOGN-1:0] h_wa [0:NCAP];
    logic [LOGN-1:0] h_wb [0:NCAP];
    logic [KW-1:0]   h_tw [0:NCAP];

    int ram [2][N];
    int pend_x [NCAP+D+2];
    int pend_y [NCAP+D+2];
    int ea  [LOGN][HALF_N];
    int eb  [LOGN][HALF_N];
    int etw [LOGN][HALF_N];

    fft_stage_seq dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .stage     (stage),
        .rd_en     (rd_en),
        .rd_bank   (rd_bank),
        .rd_addr_a (rd_addr_a),
        .rd_addr_b (rd_addr_b),
        .tw_addr   (tw_addr),
        .wr_en     (wr_en),
        .wr_bank   (wr_bank),
        .wr_addr_a (wr_addr_a),
        .wr_addr_b (wr_addr_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] all_outs();
        return 32'({busy, done, stage, rd_en, rd_bank, rd_addr_a, rd_addr_b, tw_addr,
                    wr_en, wr_bank, wr_addr_a, wr_addr_b});
    endfunction

    // Textbook pair enumeration: groups of 2*span, pairs (base+j, base+j+span).
    task automatic build_model();
        int span, idx;
        for (int s = 0; s < int'(LOGN); s++) begin
            span = 1 << s;
            idx  = 0;
            for (int base = 0; base < int'(N); base += 2 * span) begin
                for (int j = 0; j < span; j++) begin
                    ea[s][idx]  = base + j;
                    eb[s][idx]  = base + j + span;
                    etw[s][idx] = j * (int'(HALF_N) / span);
                    idx++;
                end
            end
        end
    endtask

    // Launch a run from IDLE and record cycles 1..NCAP; optional stray start pulse.
    task automatic run_capture(input int pulse_at);
        int ra, rb;
        for (int b = 0; b < 2; b++)
            for (int i = 0; i < int'(N); i++) ram[b][i] = 0;
        ram[0][0] = 1;
        for (int i = 0; i < NCAP + int'(D) + 2; i++) begin
            pend_x[i] = 0;
            pend_y[i] = 0;
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c <= NCAP; c++) begin
            start        = 1'(c == pulse_at);
            h_rd_en[c]   = rd_en;
            h_rd_bank[c] = rd_bank;
            h_busy[c]    = busy;
            h_done[c]    = done;
            h_wr_en[c]   = wr_en;
            h_wr_bank[c] = wr_bank;
            h_stage[c]   = stage;
            h_ra[c]      = rd_addr_a;
            h_rb[c]      = rd_addr_b;
            h_wa[c]      = wr_addr_a;
            h_wb[c]      = wr_addr_b;
            h_tw[c]      = tw_addr;
            if (rd_en === 1'b1) begin
                ra = ram[rd_bank][rd_addr_a];
                rb = ram[rd_bank][rd_addr_b];
                pend_x[c + int'(D)] = ra + rb;
                pend_y[c + int'(D)] = ra - rb;
            end
            if (wr_en === 1'b1) begin
                ram[wr_bank][wr_addr_a] = pend_x[c];
                ram[wr_bank][wr_addr_b] = pend_y[c];
            end
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    task automatic check_run(input string tag);
        int s, w, pc, ps, pk, total;
        bit in_run, e_rd, e_wr;
        int wcnt [LOGN];
        for (int i = 0; i < int'(LOGN); i++) wcnt[i] = 0;
        for (int c = 1; c <= NCAP; c++) begin
            s      = (c - 1) / STG_CYC;
            w      = (c - 1) % STG_CYC;
            in_run = (c < RUN_CYC);
            e_rd   = in_run && (w < int'(HALF_N));
            chk($sformatf("%s rd_en c%0d", tag, c), 32'(h_rd_en[c]), 32'(e_rd));
            chk($sformatf("%s busy c%0d", tag, c), 32'(h_busy[c]), 32'(in_run));
            chk($sformatf("%s done c%0d", tag, c), 32'(h_done[c]), 32'(c == RUN_CYC));
            chk($sformatf("%s stage c%0d", tag, c), 32'(h_stage[c]), in_run ? 32'(s) : 32'd0);
            if (e_rd) begin
                chk($sformatf("%s rd_a s%0d k%0d", tag, s, w), 32'(h_ra[c]), 32'(ea[s][w]));
                chk($sformatf("%s rd_b s%0d k%0d", tag, s, w), 32'(h_rb[c]), 32'(eb[s][w]));
                chk($sformatf("%s tw s%0d k%0d", tag, s, w), 32'(h_tw[c]), 32'(etw[s][w]));
                chk($sformatf("%s rd_bank s%0d", tag, s), 32'(h_rd_bank[c]), 32'(s % 2));
            end
            pc   = c - int'(D);
            e_wr = (pc >= 1) && (pc < RUN_CYC) && (((pc - 1) % STG_CYC) < int'(HALF_N));
            chk($sformatf("%s wr_en c%0d", tag, c), 32'(h_wr_en[c]), 32'(e_wr));
            if (e_wr) begin
                ps = (pc - 1) / STG_CYC;
                pk = (pc - 1) % STG_CYC;
                chk($sformatf("%s wr_a s%0d k%0d", tag, ps, pk), 32'(h_wa[c]), 32'(ea[ps][pk]));
                chk($sformatf("%s wr_b s%0d k%0d", tag, ps, pk), 32'(h_wb[c]), 32'(eb[ps][pk]));
                chk($sformatf("%s wr_bank s%0d", tag, ps), 32'(h_wr_bank[c]), 32'((ps + 1) % 2));
            end
            if (h_wr_en[c] === 1'b1 && s < int'(LOGN)) wcnt[s]++;
        end
        total = 0;
        for (int i = 0; i < int'(LOGN); i++) begin
            chk($sformatf("%s writes stage%0d", tag, i), 32'(wcnt[i]), 32'd8);
            total += wcnt[i];
        end
        chk($sformatf("%s writes total", tag), 32'(total), 32'd32);
        for (int i = 0; i < int'(N); i++)
            chk($sformatf("%s impulse out[%0d]", tag, i), 32'(ram[LOGN % 2][i]), 32'd1);
    endtask

    task automatic check_hand();
        int s0a [8] = '{0, 2, 4, 6, 8, 10, 12, 14};
        int s2a [8] = '{0, 1, 2, 3, 8, 9, 10, 11};
        int s2t [8] = '{0, 2, 4, 6, 0, 2, 4, 6};
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("hand s0 a[%0d]", i), 32'(h_ra[1 + i]), 32'(s0a[i]));
            chk($sformatf("hand s0 b[%0d]", i), 32'(h_rb[1 + i]), 32'(s0a[i] + 1));
            chk($sformatf("hand s0 tw[%0d]", i), 32'(h_tw[1 + i]), 32'd0);
            chk($sformatf("hand s2 a[%0d]", i), 32'(h_ra[27 + i]), 32'(s2a[i]));
            chk($sformatf("hand s2 b[%0d]", i), 32'(h_rb[27 + i]), 32'(s2a[i] + 4));
            chk($sformatf("hand s2 tw[%0d]", i), 32'(h_tw[27 + i]), 32'(s2t[i]));
        end
    endtask

    initial begin
        int cnt;
        rst   = 1'b1;
        start = 1'b0;
        build_model();
        repeat (3) @(negedge clk);
        chk("reset outputs", all_outs(), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle outputs", all_outs(), 32'd0);

        // Plain run, then a run with a stray start during stage 1 ISSUE.
        run_capture(0);
        check_run("run1");
        check_hand();
        run_capture(15);
        check_run("run2");

        // start held high: back-to-back runs with one IDLE cycle between.
        start = 1'b1;
        @(negedge clk);
        cnt = 1;
        while (done !== 1'b1 && cnt < 100) begin
            @(negedge clk);
            cnt++;
        end
        chk("hold done cycle", 32'(cnt), 32'd53);
        @(negedge clk);
        chk("hold gap busy", 32'(busy), 32'd0);
        chk("hold gap rd_en", 32'(rd_en), 32'd0);
        @(negedge clk);
        chk("hold restart busy", 32'(busy), 32'd1);
        chk("hold restart rd", 32'({rd_en, rd_addr_a, rd_addr_b}), 32'({1'b1, 4'd0, 4'd1}));
        start = 1'b0;
        cnt = 1;
        while (done !== 1'b1 && cnt < 100) begin
            @(negedge clk);
            cnt++;
        end
        chk("hold second done cycle", 32'(cnt), 32'd53);
        repeat (3) @(negedge clk);

        // Reset during stage 2 DRAIN while writes are still in flight.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (35) @(negedge clk);
        chk("pre-rst stage", 32'(stage), 32'd2);
        chk("pre-rst drain", 32'({busy, rd_en, wr_en}), 32'(3'b101));
        rst = 1'b1;
        #1;
        chk("async rst outputs", all_outs(), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk($sformatf("post-rst quiet c%0d", i), 32'({busy, wr_en, rd_en}), 32'd0);
        end
        run_capture(0);
        check_run("run_after_rst");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
